// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad-driven 4-digit BCD calculator controller.
//   clk_i/rst_i        clock, synchronous active-high reset
//   key_valid_i        one-cycle key strobe
//   key_code_i         0-9 digit, A plus, B minus, C equals, D clear, E/F unused
//   sum_i/carry_i      external BCD adder result for a_o + b_o
//   diff_i/borrow_i    external BCD subtractor result for a_o - b_o
//   a_o/b_o            registered operands (feed the external adder/subtractor)
//   disp_o             4 BCD digits for the display driver
//   neg_o/ovf_o        result flags, only ever set while showing a result
//   busy_o             high while computing; keys are dropped
module calc_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        key_valid_i,
  input  logic [3:0]  key_code_i,
  input  logic [15:0] sum_i,
  input  logic        carry_i,
  input  logic [15:0] diff_i,
  input  logic        borrow_i,
  output logic [15:0] a_o,
  output logic [15:0] b_o,
  output logic [15:0] disp_o,
  output logic        neg_o,
  output logic        ovf_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    ENTRY_A,
    ENTRY_B,
    CALC,
    SWAP,
    SHOW
  } state_e;

  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_MINUS = 4'hB;
  localparam logic [3:0] KEY_EQ    = 4'hC;
  localparam logic [3:0] KEY_CLR   = 4'hD;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] res_q, res_d;
  logic        op_q, op_d;      // 0 plus, 1 minus
  logic [2:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        ovf_q, ovf_d;
  logic [15:0] disp_q, disp_d;
  logic        busy_q, busy_d;

  logic key_acc;
  logic is_digit;
  logic is_op;
  logic op_sel;

  always_comb begin
    key_acc  = key_valid_i && !busy_q;
    is_digit = (key_code_i <= 4'd9);
    is_op    = (key_code_i == KEY_PLUS) || (key_code_i == KEY_MINUS);
    op_sel   = (key_code_i == KEY_MINUS);

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;

    if (key_acc && (key_code_i == KEY_CLR)) begin
      state_d = ENTRY_A;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      op_d    = 1'b0;
      cnt_d   = '0;
      neg_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ENTRY_A: begin
          if (key_acc) begin
            if (is_digit) begin
              if (cnt_q < 3'd4) begin
                a_d   = {a_q[11:0], key_code_i};
                cnt_d = cnt_q + 3'd1;
              end
            end else if (is_op) begin
              op_d    = op_sel;
              b_d     = '0;
              cnt_d   = '0;
              state_d = ENTRY_B;
            end
          end
        end

        ENTRY_B: begin
          if (key_acc) begin
            if (is_digit) begin
              if (cnt_q < 3'd4) begin
                b_d   = {b_q[11:0], key_code_i};
                cnt_d = cnt_q + 3'd1;
              end
            end else if (is_op) begin
              // Operator may be changed only before any B digit is typed.
              if (cnt_q == 3'd0) begin
                op_d = op_sel;
              end
            end else if (key_code_i == KEY_EQ) begin
              state_d = CALC;
            end
          end
        end

        CALC: begin
          if (!op_q) begin
            res_d   = sum_i;
            ovf_d   = carry_i;
            neg_d   = 1'b0;
            state_d = SHOW;
          end else if (!borrow_i) begin
            res_d   = diff_i;
            neg_d   = 1'b0;
            state_d = SHOW;
          end else begin
            // Negative result: swap operands so the subtractor yields |A-B|.
            a_d     = b_q;
            b_d     = a_q;
            state_d = SWAP;
          end
        end

        SWAP: begin
          res_d   = diff_i;
          neg_d   = 1'b1;
          ovf_d   = 1'b0;
          state_d = SHOW;
        end

        SHOW: begin
          if (key_acc) begin
            if (is_digit) begin
              a_d     = {12'h000, key_code_i};
              b_d     = '0;
              cnt_d   = 3'd1;
              neg_d   = 1'b0;
              ovf_d   = 1'b0;
              state_d = ENTRY_A;
            end else if (is_op && !neg_q && !ovf_q) begin
              a_d     = res_q;
              b_d     = '0;
              cnt_d   = '0;
              op_d    = op_sel;
              neg_d   = 1'b0;
              ovf_d   = 1'b0;
              state_d = ENTRY_B;
            end
          end
        end

        default: begin
          state_d = ENTRY_A;
        end
      endcase
    end

    // Display and busy are registered from next-state values so they
    // line up with the state they describe.
    case (state_d)
      ENTRY_B: disp_d = b_d;
      SHOW:    disp_d = res_d;
      default: disp_d = a_d;
    endcase
    busy_d = (state_d == CALC) || (state_d == SWAP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ENTRY_A;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
    end
  end

  assign a_o    = a_q;
  assign b_o    = b_q;
  assign disp_o = disp_q;
  assign neg_o  = neg_q;
  assign ovf_o  = ovf_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Bench for calc_ctrl: directed vector table plus randomized keys against
// a decimal-arithmetic reference model. The external BCD adder/subtractor
// is emulated from a_o/b_o.
module tb_calc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        kv;
  logic [3:0]  key;
  logic [15:0] sum, diff, a, b, disp;
  logic        carry, borrow, neg, ovf, busy;

  always #5 clk = ~clk;

  calc_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .key_valid_i (kv),
    .key_code_i  (key),
    .sum_i       (sum),
    .carry_i     (carry),
    .diff_i      (diff),
    .borrow_i    (borrow),
    .a_o         (a),
    .b_o         (b),
    .disp_o      (disp),
    .neg_o       (neg),
    .ovf_o       (ovf),
    .busy_o      (busy)
  );

  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic int unsigned from_bcd(input logic [15:0] v);
    return 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
  endfunction

  // External 4-digit BCD adder / ten's-complement subtractor.
  int unsigned ea, eb;
  always_comb begin
    ea    = from_bcd(a);
    eb    = from_bcd(b);
    sum   = to_bcd((ea + eb) % 10000);
    carry = (ea + eb) > 9999;
    if (ea >= eb) begin
      diff   = to_bcd(ea - eb);
      borrow = 1'b0;
    end else begin
      diff   = to_bcd(ea + 10000 - eb);
      borrow = 1'b1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: decimal operands, phase 0 = typing A, 1 = typing B,
  // 2 = result shown. Results are computed with plain arithmetic at equals
  // and released after the 1- or 2-cycle compute delay.
  int unsigned m_a, m_b, m_res, m_cnt, m_phase, m_busy;
  int unsigned p_res;
  bit          m_minus, m_neg, m_ovf, p_neg, p_ovf;

  task automatic model_reset();
    m_a = 0; m_b = 0; m_res = 0; m_cnt = 0; m_phase = 0; m_busy = 0;
    m_minus = 0; m_neg = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [3:0] k);
    int unsigned t;
    if (r || (v && m_busy == 0 && k == 4'hD)) begin
      model_reset();
    end else if (m_busy > 0) begin
      if (m_busy == 2) begin
        t = m_a; m_a = m_b; m_b = t;
      end
      m_busy--;
      if (m_busy == 0) begin
        m_phase = 2; m_res = p_res; m_neg = p_neg; m_ovf = p_ovf;
      end
    end else if (v) begin
      case (m_phase)
        0: begin
          if (k <= 9) begin
            if (m_cnt < 4) begin m_a = (m_a * 10 + k) % 10000; m_cnt++; end
          end else if (k == 4'hA || k == 4'hB) begin
            m_minus = (k == 4'hB); m_b = 0; m_cnt = 0; m_phase = 1;
          end
        end
        1: begin
          if (k <= 9) begin
            if (m_cnt < 4) begin m_b = (m_b * 10 + k) % 10000; m_cnt++; end
          end else if (k == 4'hA || k == 4'hB) begin
            if (m_cnt == 0) m_minus = (k == 4'hB);
          end else if (k == 4'hC) begin
            if (!m_minus) begin
              p_res = (m_a + m_b) % 10000; p_ovf = (m_a + m_b) > 9999; p_neg = 0; m_busy = 1;
            end else if (m_a >= m_b) begin
              p_res = m_a - m_b; p_ovf = 0; p_neg = 0; m_busy = 1;
            end else begin
              p_res = m_b - m_a; p_ovf = 0; p_neg = 1; m_busy = 2;
            end
          end
        end
        default: begin
          if (k <= 9) begin
            m_a = k; m_b = 0; m_cnt = 1; m_neg = 0; m_ovf = 0; m_phase = 0;
          end else if ((k == 4'hA || k == 4'hB) && !m_neg && !m_ovf) begin
            m_a = m_res; m_b = 0; m_cnt = 0; m_minus = (k == 4'hB);
            m_neg = 0; m_ovf = 0; m_phase = 1;
          end
        end
      endcase
    end
  endtask

  task automatic check_model();
    cmp("mdl_a", a, to_bcd(m_a));
    cmp("mdl_b", b, to_bcd(m_b));
    cmp("mdl_neg", 16'(neg), 16'(m_neg));
    cmp("mdl_ovf", 16'(ovf), 16'(m_ovf));
    cmp("mdl_busy", 16'(busy), 16'(m_busy > 0));
    if (m_busy == 0)
      cmp("mdl_disp", disp, to_bcd(m_phase == 0 ? m_a : (m_phase == 1 ? m_b : m_res)));
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] k);
    rst = r; kv = v; key = k;
    @(posedge clk);
    model_edge(r, v, k);
    #1;
    check_model();
  endtask

  typedef struct {
    logic        rst;
    logic        kv;
    logic [3:0]  key;
    logic        chk;
    logic        dx;    // disp not checked (busy cycles)
    logic [15:0] disp;
    logic        neg;
    logic        ovf;
    logic        busy;
    logic [15:0] a;
    logic [15:0] b;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic [3:0] k, input logic c,
                     input logic x, input logic [15:0] d, input logic n, input logic o,
                     input logic bz, input logic [15:0] ea_, input logic [15:0] eb_);
    vec_t e;
    e.rst = r; e.kv = v; e.key = k; e.chk = c; e.dx = x; e.disp = d;
    e.neg = n; e.ovf = o; e.busy = bz; e.a = ea_; e.b = eb_;
    tbl.push_back(e);
  endtask

  task automatic kp(input logic [3:0] k);
    add(1'b0, 1'b1, k, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic ck(input logic r, input logic v, input logic [3:0] k, input logic x,
                    input logic [15:0] d, input logic n, input logic o, input logic bz,
                    input logic [15:0] ea_, input logic [15:0] eb_);
    add(r, v, k, 1'b1, x, d, n, o, bz, ea_, eb_);
  endtask

  task automatic clr();
    ck(0, 1, 4'hD, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; kv = 1'b0; key = 4'h0;
    model_reset();

    ck(1, 0, 4'h0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    // 1234 + 5678
    kp(1); kp(2); kp(3); kp(4);
    ck(0, 1, 4'hA, 0, 16'h0000, 0, 0, 0, 16'h1234, 16'h0000);
    kp(5); kp(6); kp(7);
    ck(0, 1, 4'h8, 0, 16'h5678, 0, 0, 0, 16'h1234, 16'h5678);
    ck(0, 1, 4'hC, 1, 16'h0000, 0, 0, 1, 16'h1234, 16'h5678);
    ck(0, 0, 4'h0, 0, 16'h6912, 0, 0, 0, 16'h1234, 16'h5678);
    clr();
    // 9999 + 1 overflows; operator then ignored; digit restarts entry
    kp(9); kp(9); kp(9); kp(9); kp(4'hA); kp(1);
    ck(0, 1, 4'hC, 1, 16'h0000, 0, 0, 1, 16'h9999, 16'h0001);
    ck(0, 0, 4'h0, 0, 16'h0000, 0, 1, 0, 16'h9999, 16'h0001);
    ck(0, 1, 4'hA, 0, 16'h0000, 0, 1, 0, 16'h9999, 16'h0001);
    ck(0, 1, 4'h2, 0, 16'h0002, 0, 0, 0, 16'h0002, 16'h0000);
    clr();
    // 5 - 12 = -7, two busy cycles, keys during busy dropped
    kp(5); kp(4'hB); kp(1);
    ck(0, 1, 4'h2, 0, 16'h0012, 0, 0, 0, 16'h0005, 16'h0012);
    ck(0, 1, 4'hC, 1, 16'h0000, 0, 0, 1, 16'h0005, 16'h0012);
    ck(0, 1, 4'h9, 1, 16'h0000, 0, 0, 1, 16'h0012, 16'h0005);
    ck(0, 1, 4'h7, 0, 16'h0007, 1, 0, 0, 16'h0012, 16'h0005);
    ck(0, 1, 4'hB, 0, 16'h0007, 1, 0, 0, 16'h0012, 16'h0005);
    ck(0, 1, 4'hC, 0, 16'h0007, 1, 0, 0, 16'h0012, 16'h0005);
    clr();
    // 5th digit ignored, operator replaced, then chaining
    kp(1); kp(2); kp(3); kp(4);
    ck(0, 1, 4'h5, 0, 16'h1234, 0, 0, 0, 16'h1234, 16'h0000);
    kp(4'hB); kp(4'hA);
    ck(0, 1, 4'h1, 0, 16'h0001, 0, 0, 0, 16'h1234, 16'h0001);
    ck(0, 1, 4'hC, 1, 16'h0000, 0, 0, 1, 16'h1234, 16'h0001);
    ck(0, 0, 4'h0, 0, 16'h1235, 0, 0, 0, 16'h1234, 16'h0001);
    ck(0, 1, 4'hB, 0, 16'h0000, 0, 0, 0, 16'h1235, 16'h0000);
    kp(5);
    ck(0, 1, 4'hC, 1, 16'h0000, 0, 0, 1, 16'h1235, 16'h0005);
    ck(0, 0, 4'h0, 0, 16'h1230, 0, 0, 0, 16'h1235, 16'h0005);
    clr();
    // reset during SWAP beats pending key and swap
    kp(1); kp(4'hB); kp(2);
    ck(0, 1, 4'hC, 1, 16'h0000, 0, 0, 1, 16'h0001, 16'h0002);
    ck(0, 0, 4'h0, 1, 16'h0000, 0, 0, 1, 16'h0002, 16'h0001);
    ck(1, 1, 4'h5, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    ck(0, 0, 4'h0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    ck(0, 1, 4'h6, 0, 16'h0006, 0, 0, 0, 16'h0006, 16'h0000);
    ck(0, 1, 4'hE, 0, 16'h0006, 0, 0, 0, 16'h0006, 16'h0000);
    ck(0, 1, 4'hF, 0, 16'h0006, 0, 0, 0, 16'h0006, 16'h0000);
    ck(0, 1, 4'hC, 0, 16'h0006, 0, 0, 0, 16'h0006, 16'h0000);
    clr();
    // clear from ENTRY_B
    kp(4); kp(2);
    ck(0, 1, 4'hA, 0, 16'h0000, 0, 0, 0, 16'h0042, 16'h0000);
    clr();
    ck(0, 1, 4'h7, 0, 16'h0007, 0, 0, 0, 16'h0007, 16'h0000);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].kv, tbl[i].key);
      if (tbl[i].chk) begin
        if (!tbl[i].dx) cmp("tbl_disp", disp, tbl[i].disp);
        cmp("tbl_neg", 16'(neg), 16'(tbl[i].neg));
        cmp("tbl_ovf", 16'(ovf), 16'(tbl[i].ovf));
        cmp("tbl_busy", 16'(busy), 16'(tbl[i].busy));
        cmp("tbl_a", a, tbl[i].a);
        cmp("tbl_b", b, tbl[i].b);
      end
    end

    for (int i = 0; i < 4000; i++) begin
      int unsigned r;
      logic [3:0]  k;
      r = $urandom_range(0, 99);
      if (r < 55)      k = 4'($urandom_range(0, 9));
      else if (r < 63) k = 4'hA;
      else if (r < 70) k = 4'hB;
      else if (r < 84) k = 4'hC;
      else if (r < 87) k = 4'hD;
      else             k = 4'($urandom_range(14, 15));
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-003 SHALL have port key_valid_i  input  1  one-cycle strobe, key_code_i valid.
REQ-004 SHALL have port key_code_i  input  4  key: 0-9 digit, A plus, B minus, C equals, D clear, E/F unused.
REQ-005 SHALL have port sum_i  input  16  BCD A+B from external 4-digit adder chain (combinational).
REQ-006 SHALL have port carry_i  input  1  adder chain carry-out.
REQ-007 SHALL have port diff_i  input  16  BCD A-B from external subtractor chain (combinational).
REQ-008 SHALL have port borrow_i  input  1  subtractor chain borrow-out.
REQ-009 SHALL have port a_o  output  16  operand A, 4 BCD digits, [15:12] thousands.
REQ-010 SHALL have port b_o  output  16  operand B, same format.
REQ-011 SHALL have port disp_o  output  16  4 BCD digits for display driver.
REQ-012 SHALL have port neg_o  output  1  displayed result is negative.
REQ-013 SHALL have port ovf_o  output  1  displayed sum exceeded 9999.
REQ-014 SHALL have port busy_o  output  1  high in CALC/SWAP; keys dropped.

Function
REQ-015 SHALL implement FSM states ENTRY_A, ENTRY_B, CALC, SWAP, SHOW, and registers a, b, res (16 b each), op (0 plus, 1 minus), cnt (0-4), neg, ovf.
REQ-016 SHALL act on a key only in cycles where key_valid_i=1 and busy_o=0; codes E/F ignored in all states.
REQ-017 Digit entry SHALL be: operand <= {operand[11:0], key}, cnt+1, only when cnt<4; the 5th+ digit is ignored with no state change.
REQ-018 ENTRY_A: digit -> enter into a; plus/minus -> op set, b<=0, cnt<=0, go ENTRY_B; equals ignored.
REQ-019 ENTRY_B: digit -> enter into b; plus/minus with cnt=0 -> replace op, otherwise ignored; equals -> CALC.
REQ-020 CALC (exactly 1 cycle): op=plus -> res<=sum_i, ovf<=carry_i, neg<=0, go SHOW; op=minus and borrow_i=0 -> res<=diff_i, neg<=0, go SHOW; op=minus and borrow_i=1 -> swap a and b, go SWAP.
REQ-021 SWAP (exactly 1 cycle): res<=diff_i, neg<=1, ovf<=0, go SHOW.
REQ-022 Latency SHALL be: equals accepted at edge n -> result, flags valid after edge n+1 (plus, non-negative minus) or n+2 (negative minus).
REQ-023 SHOW: digit -> a<={12'b0,key}, b<=0, cnt<=1, neg<=0, ovf<=0, go ENTRY_A; plus/minus with neg=0 and ovf=0 -> a<=res, b<=0, cnt<=0, op set, flags cleared, go ENTRY_B (chaining); plus/minus with neg or ovf set ignored; equals ignored.
REQ-024 Clear key (D) in any non-busy state SHALL perform the same actions as reset.
REQ-025 disp_o SHALL be a in ENTRY_A, b in ENTRY_B, a in CALC/SWAP (unchanged from prior cycle's visible value is acceptable only for CALC/SWAP), res in SHOW.
REQ-026 neg_o and ovf_o SHALL be registered flags, low in all states except SHOW.
REQ-027 a_o/b_o SHALL be registered; operands presented to adder/subtractor are exactly a_o/b_o.

Reset
REQ-028 rst_i=1 at a clock edge SHALL force: state ENTRY_A, a=b=res=0, cnt=0, op=plus, neg=ovf=0; hence a_o=b_o=disp_o=16'h0000, neg_o=ovf_o=busy_o=0.
REQ-029 Reset SHALL take priority over any key and over CALC/SWAP in progress; a reset during SWAP leaves no swapped operands or neg flag.

Verification
REQ-030 Keys 1,2,3,4,A,5,6,7,8,C -> disp_o=16'h6912, neg_o=0, ovf_o=0 one cycle after C edge; busy_o high 1 cycle.
REQ-031 Keys 9,9,9,9,A,1,C -> disp_o=16'h0000, ovf_o=1; then A -> ignored, state stays SHOW.
REQ-032 Keys 5,B,1,2,C -> busy_o high 2 cycles, disp_o=16'h0007, neg_o=1, a_o=16'h0012, b_o=16'h0005.
REQ-033 Keys 1,2,3,4,5 -> a_o=16'h1234; then B,A (cnt=0) -> op=plus; 1,C -> disp_o=16'h1235; then B,5,C -> chained result 16'h1230.
REQ-034 Key strobe during busy_o=1 -> dropped (no digit entered); rst_i during SWAP -> all outputs zero next cycle, state ENTRY_A.
REQ-035 Clear key D from ENTRY_B with a=16'h0042 -> all outputs zero, next digit 7 gives a_o=16'h0007.
